// File: rtl/hysteresis_stage.sv
// rtl/hysteresis_stage.sv - Canny double-threshold + single-pass 8-neighbour hysteresis over a raster magnitude stream.
// Optional feature macro: HYST_BORDER_CLEAR_EN (forces result 0 on the frame border).
module hysteresis_stage #(
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 512,
    parameter int DATA_W  = 8,
    parameter int HIGH_TH = 100,
    parameter int LOW_TH  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mag,
    output logic              hysteresis_result,
    output logic              write_enable,
    output logic [9:0]        x_value,
    output logic [9:0]        y_value,
    output logic              file_dump,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DUMP, S_DONE} state_t;

    localparam int                AW       = $clog2(IMG_W);
    localparam int                NPIX     = IMG_W * IMG_H;
    localparam logic [20:0]       LAST_IN  = 21'(NPIX - 1);
    localparam logic [20:0]       LAST_FL  = 21'(NPIX + IMG_W);
    localparam logic [20:0]       FIRST_WR = 21'(IMG_W + 1);
    localparam logic [AW-1:0]     LAST_P   = AW'(IMG_W - 1);
    localparam logic [9:0]        LAST_X   = 10'(IMG_W - 1);
    localparam logic [9:0]        LAST_Y   = 10'(IMG_H - 1);
    localparam logic [DATA_W-1:0] HI       = DATA_W'(HIGH_TH);
    localparam logic [DATA_W-1:0] LO       = DATA_W'(LOW_TH);

    state_t        state, state_next;
    logic [20:0]   t;
    logic [AW-1:0] p;
    logic [9:0]    cx, cy;
    logic          tick, flush;
    logic [1:0]    lb0 [IMG_W];
    logic [1:0]    lb1 [IMG_W];
    logic [1:0]    win [3][3];
    logic [1:0]    nw  [3][3];
    logic [1:0]    new_cls;
    logic          strong_nb, res;

    assign in_ready = (state == S_RUN);
    assign busy     = (state != S_IDLE);
    assign flush    = (state == S_FLUSH);
    assign tick     = (in_valid && in_ready) || flush;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (in_valid && t == LAST_IN) state_next = S_FLUSH;
            S_FLUSH: if (t == LAST_FL) state_next = S_DUMP;
            S_DUMP:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Window after this tick's shift: column 2 is the incoming column, centre is (cx, cy).
    always_comb begin
        new_cls = 2'd0;
        if (!flush) begin
            if (in_mag >= HI)      new_cls = 2'd2;
            else if (in_mag >= LO) new_cls = 2'd1;
        end
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = win[r][1];
            nw[r][1] = win[r][2];
        end
        nw[0][2] = lb0[p];
        nw[1][2] = lb1[p];
        nw[2][2] = new_cls;
        strong_nb = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) && nw[r][c] == 2'd2 &&
                    !((c == 0 && cx == 10'd0) || (c == 2 && cx == LAST_X) ||
                      (r == 0 && cy == 10'd0) || (r == 2 && cy == LAST_Y)))
                    strong_nb = 1'b1;
            end
        end
        res = (nw[1][1] == 2'd2) || (nw[1][1] == 2'd1 && strong_nb);
`ifdef HYST_BORDER_CLEAR_EN
        if (cx == 10'd0 || cx == LAST_X || cy == 10'd0 || cy == LAST_Y) res = 1'b0;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t                 <= '0;
            p                 <= '0;
            cx                <= '0;
            cy                <= '0;
            write_enable      <= 1'b0;
            hysteresis_result <= 1'b0;
            x_value           <= '0;
            y_value           <= '0;
            file_dump         <= 1'b0;
            done              <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            file_dump    <= (state == S_DUMP);
            done         <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                t  <= '0;
                p  <= '0;
                cx <= '0;
                cy <= '0;
            end
            if (tick) begin
                t <= t + 21'd1;
                p <= (p == LAST_P) ? '0 : p + AW'(1);
                if (t >= FIRST_WR) begin
                    write_enable      <= 1'b1;
                    hysteresis_result <= res;
                    x_value           <= cx;
                    y_value           <= cy;
                    if (cx == LAST_X) begin
                        cx <= '0;
                        cy <= cy + 10'd1;
                    end else begin
                        cx <= cx + 10'd1;
                    end
                end
            end
        end
    end

    // Storage contents are masked until valid, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (tick) begin
            lb0[p] <= lb1[p];
            lb1[p] <= new_cls;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= nw[r][0];
                win[r][1] <= nw[r][1];
                win[r][2] <= nw[r][2];
            end
        end
    end
endmodule

// File: tb/tb_hysteresis_stage.sv
// tb/tb_hysteresis_stage.sv - directed self-checking bench for hysteresis_stage (8x4 frame).
module tb_hysteresis_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_mag = '0;
    logic       hysteresis_result, write_enable, file_dump, busy, done;
    logic [9:0] x_value, y_value;

    hysteresis_stage #(.IMG_W(8), .IMG_H(4), .DATA_W(8), .HIGH_TH(100), .LOW_TH(40)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mag(in_mag), .hysteresis_result(hysteresis_result), .write_enable(write_enable),
        .x_value(x_value), .y_value(y_value), .file_dump(file_dump), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    logic [7:0]  img [32];
    logic [31:0] wr_res;
    int wr_x [32], wr_y [32];
    int wr_cnt, dump_cnt, done_cnt, overlap;
    int first_tick, first_wr, last_wr, dump_cyc, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_enable) begin
            if (wr_cnt < 32) begin
                wr_res[wr_cnt] = hysteresis_result;
                wr_x[wr_cnt]   = int'(x_value);
                wr_y[wr_cnt]   = int'(y_value);
            end
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            if (file_dump) overlap++;
            wr_cnt++;
        end
        if (file_dump) begin dump_cnt++; dump_cyc = cyc; end
        if (done)      begin done_cnt++; done_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0; dump_cnt = 0; done_cnt = 0; overlap = 0;
        first_tick = -1; first_wr = -1; last_wr = -1; dump_cyc = -1; done_cyc = -1;
        wr_res = '1;
        for (int i = 0; i < 32; i++) begin wr_x[i] = -1; wr_y[i] = -1; end
    endtask

    task automatic set_img(input int a, input logic [7:0] va, input int b, input logic [7:0] vb,
                           input int c, input logic [7:0] vc);
        for (int i = 0; i < 32; i++) img[i] = 8'd0;
        if (a >= 0) img[a] = va;
        if (b >= 0) img[b] = vb;
        if (c >= 0) img[c] = vc;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap);
        int idx = 0, guard = 0;
        bit v = 1'b1, acc;
        while (idx < n && guard < 2000) begin
            @(negedge clk);
            in_valid = v;
            in_mag   = img[idx];
            acc      = v && in_ready;
            if (acc && idx == 0) first_tick = cyc;
            if (gap) v = !v;
            @(posedge clk);
            if (acc) idx++;
            guard++;
        end
        #1 in_valid = 1'b0;
        check("feed_accepted", idx, n);
    endtask

    task automatic run_frame(input string name, input bit gap, input logic [31:0] exp, input bit timing);
        int g = 0, bad = 0;
        clear_log();
        pulse_start();
        feed(32, gap);
        while (done_cnt == 0 && g < 300) begin @(negedge clk); g++; end
        repeat (5) @(negedge clk);
        check({name, "_done_seen"}, done_cnt, 1);
        check({name, "_wr_cnt"}, wr_cnt, 32);
        check({name, "_dump_cnt"}, dump_cnt, 1);
        for (int i = 0; i < 32; i++) if (wr_x[i] != i % 8 || wr_y[i] != i / 8) bad++;
        check({name, "_order_errs"}, bad, 0);
        check({name, "_results"}, wr_res, exp);
        check({name, "_dump_overlap"}, overlap, 0);
        check({name, "_dump_after_last"}, dump_cyc - last_wr, 1);
        check({name, "_done_after_dump"}, done_cyc - dump_cyc, 1);
        if (timing) check({name, "_first_latency"}, first_wr - first_tick, 10);
    endtask

    initial begin
        clear_log();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {22'd0, in_ready, hysteresis_result, write_enable, file_dump, busy, done},
              32'd0);
        check("reset_xy", {x_value, y_value}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_not_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        set_img(-1, 0, -1, 0, -1, 0);
        run_frame("t1_zero", 1'b0, 32'h0000_0000, 1'b1);

        set_img(11, 8'd120, 20, 8'd50, 22, 8'd50);
        run_frame("t2_weak", 1'b0, 32'h0010_0800, 1'b1);

        set_img(7, 8'd120, 8, 8'd50, -1, 0);
        run_frame("t3_nowrap", 1'b0, 32'h0000_0080, 1'b1);

        set_img(11, 8'd120, 20, 8'd50, 22, 8'd50);
        run_frame("t4_gaps", 1'b1, 32'h0010_0800, 1'b0);

        clear_log();
        pulse_start();
        feed(10, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 clear_log();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_wr_after_rst", wr_cnt, 0);
        check("t5_no_dump_after_rst", dump_cnt + done_cnt, 0);
        check("t5_idle_after_rst", {31'd0, busy}, 32'd0);
        run_frame("t5_restart", 1'b0, 32'h0010_0800, 1'b1);

        set_img(0, 8'd120, -1, 0, -1, 0);
`ifdef HYST_BORDER_CLEAR_EN
        run_frame("t6_corner", 1'b0, 32'h0000_0000, 1'b1);
`else
        run_frame("t6_corner", 1'b0, 32'h0000_0001, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
